// File: rtl/sap_main_memory.sv
// SAP main memory: bus-addressed run mode with a registered W-bus read port,
// a valid/ready manual programming stream, and a hardware clear sweep.
module sap_main_memory #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              manual_mode,
  input  logic              prog_start,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_valid,
  output logic              prog_ready,
  input  logic              mar_load,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic              w_enable,
  input  logic [DATA_W-1:0] bus_wdata,
  input  logic              r_enable,
  output logic [DATA_W-1:0] wbus_data,
  output logic              wbus_oe,
  input  logic              clear_req,
  output logic              busy,
  output logic              err
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PROG  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] mar;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] sweep_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              prog_acc;
  logic [ADDR_W-1:0] prog_wptr;
  logic              rd_req;
  logic              collide;

  logic [DATA_W-1:0] rd_data_p1;
  logic              vld_p1;
  logic              err_p1;

  // Next-state logic and the single memory write port shared by all modes
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_waddr = mar;
    mem_wdata = bus_wdata;
    prog_acc  = 1'b0;
    prog_wptr = prog_start ? prog_addr : ptr;
    rd_req    = 1'b0;
    collide   = 1'b0;
    case (state)
      ST_RUN: begin
        mem_we  = w_enable;
        rd_req  = r_enable & ~w_enable;
        collide = r_enable & w_enable;
        if (clear_req) begin
          state_nxt = ST_CLEAR;
        end else if (manual_mode) begin
          state_nxt = ST_PROG;
        end
      end
      ST_PROG: begin
        prog_acc  = manual_mode & prog_valid;
        mem_we    = prog_acc;
        mem_waddr = prog_wptr;
        mem_wdata = prog_data;
        if (!manual_mode) begin
          state_nxt = ST_RUN;
        end
      end
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = sweep_cnt;
        mem_wdata = '0;
        if (sweep_cnt == {ADDR_W{1'b1}}) begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Ready drops in the exit cycle so a word offered while leaving is refused
  assign prog_ready = (state == ST_PROG) && manual_mode;
  assign busy       = (state == ST_CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      mar       <= '0;
      ptr       <= '0;
      sweep_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_RUN && mar_load) begin
        mar <= bus_addr;
      end
      if (state == ST_PROG) begin
        if (prog_acc) begin
          ptr <= prog_wptr + 1'b1;
        end else if (prog_start) begin
          ptr <= prog_addr;
        end
      end
      if (state == ST_CLEAR) begin
        sweep_cnt <= sweep_cnt + 1'b1;
      end else begin
        sweep_cnt <= '0;
      end
    end
  end

  // Array is never reset; holding rst_n low also blocks the write of that edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // ---- read stage p0 -> p1: W-bus data, valid and collision flag ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
      err_p1     <= 1'b0;
    end else begin
      vld_p1 <= rd_req;
      err_p1 <= collide;
      if (rd_req) begin
        rd_data_p1 <= mem[mar];
      end
    end
  end

  assign wbus_data = rd_data_p1;
  assign wbus_oe   = vld_p1;
  assign err       = err_p1;

endmodule

// File: tb/tb_sap_main_memory.sv
// Directed bench for sap_main_memory: stimulus pushes expected W-bus words into
// a queue, a negedge monitor pops and compares whenever wbus_oe is high.
module tb_sap_main_memory;
  localparam int DATA_W = 4;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              manual_mode, prog_start, prog_valid, prog_ready;
  logic [ADDR_W-1:0] prog_addr, bus_addr;
  logic [DATA_W-1:0] prog_data, bus_wdata, wbus_data;
  logic              mar_load, w_enable, r_enable, wbus_oe, clear_req, busy, err;

  int errors = 0;
  int checks = 0;
  int err_seen = 0;
  int err_expected = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] mon_exp;

  sap_main_memory #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .manual_mode(manual_mode), .prog_start(prog_start),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_valid(prog_valid),
    .prog_ready(prog_ready), .mar_load(mar_load), .bus_addr(bus_addr),
    .w_enable(w_enable), .bus_wdata(bus_wdata), .r_enable(r_enable),
    .wbus_data(wbus_data), .wbus_oe(wbus_oe), .clear_req(clear_req),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every W-bus valid must match the oldest outstanding read
  always @(negedge clk) begin
    if (rst_n) begin
      if (wbus_oe) begin
        if (exp_q.size() == 0) begin
          chk("wbus_oe spurious", 32'(wbus_oe), 32'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("wbus_data", 32'(wbus_data), 32'(mon_exp));
        end
      end
      if (err) err_seen++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
    mar_load = 1'b1; bus_addr = a;
    cyc();
    mar_load = 1'b0; r_enable = 1'b1;
    exp_q.push_back(e);
    cyc();
    r_enable = 1'b0;
    cyc();
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    mar_load = 1'b1; bus_addr = a;
    cyc();
    mar_load = 1'b0; w_enable = 1'b1; bus_wdata = d;
    cyc();
    w_enable = 1'b0;
  endtask

  task automatic prog(input logic use_start, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d[4], input int n);
    manual_mode = 1'b1;
    cyc();
    chk("prog_ready in PROG", 32'(prog_ready), 32'd1);
    prog_start = use_start; prog_addr = a;
    for (int i = 0; i < n; i++) begin
      prog_data = d[i]; prog_valid = 1'b1;
      cyc();
      prog_start = 1'b0;
    end
    prog_valid = 1'b0; manual_mode = 1'b0;
    cyc();
    chk("prog_ready after exit", 32'(prog_ready), 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; manual_mode = 1'b0; prog_start = 1'b0; prog_addr = '0;
    prog_data = '0; prog_valid = 1'b0; mar_load = 1'b0; bus_addr = '0;
    w_enable = 1'b0; bus_wdata = '0; r_enable = 1'b0; clear_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset wbus_data", 32'(wbus_data), 32'd0);
    chk("reset wbus_oe", 32'(wbus_oe), 32'd0);
    chk("reset prog_ready", 32'(prog_ready), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    rst_n = 1'b1;
    cyc();

    // 1: single manual word
    prog(1'b1, 8'h0C, '{4'b1010, 4'h0, 4'h0, 4'h0}, 1);
    rd(8'h0C, 4'b1010);

    // 2: streaming across the wrap, then a resumed session without prog_start
    prog(1'b1, 8'hFE, '{4'b1110, 4'b0111, 4'b0011, 4'h0}, 3);
    rd(8'hFE, 4'b1110);
    rd(8'hFF, 4'b0111);
    rd(8'h00, 4'b0011);
    prog(1'b0, 8'h55, '{4'b1001, 4'h0, 4'h0, 4'h0}, 1);
    rd(8'h01, 4'b1001);

    // 3: run-mode write then read
    wr(8'h0A, 4'b1110);
    r_enable = 1'b1; exp_q.push_back(4'b1110);
    cyc();
    r_enable = 1'b0;
    repeat (2) cyc();

    // 4: collision writes, suppresses the read, pulses err
    w_enable = 1'b1; r_enable = 1'b1; bus_wdata = 4'b0101; err_expected++;
    cyc();
    w_enable = 1'b0; r_enable = 1'b0;
    repeat (2) cyc();
    r_enable = 1'b1; exp_q.push_back(4'b0101);
    cyc();
    r_enable = 1'b0;
    cyc();
    // read in the same cycle as mar_load uses the old MAR
    mar_load = 1'b1; bus_addr = 8'h0C; r_enable = 1'b1; exp_q.push_back(4'b0101);
    cyc();
    mar_load = 1'b0; exp_q.push_back(4'b1010);
    cyc();
    r_enable = 1'b0;
    cyc();

    // 5: full clear sweep, manual_mode and a repeated clear_req ignored
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0; manual_mode = 1'b1;
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n == 100) clear_req = 1'b1;
      if (n == 101) clear_req = 1'b0;
    end
    chk("busy cycles", 32'(n), 32'd256);
    chk("prog_ready first cycle after clear", 32'(prog_ready), 32'd0);
    @(negedge clk);
    chk("prog_ready after clear with manual_mode", 32'(prog_ready), 32'd1);
    manual_mode = 1'b0;
    cyc();
    rd(8'h0A, 4'b0000);
    rd(8'h0C, 4'b0000);
    rd(8'hFE, 4'b0000);

    // 6: reset at sweep count 0x20
    wr(8'h10, 4'b0111);
    wr(8'h20, 4'b0011);
    prog(1'b1, 8'hFE, '{4'b1110, 4'h0, 4'h0, 4'h0}, 1);
    rd(8'h10, 4'b0111);
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    chk("busy mid-clear", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async reset busy", 32'(busy), 32'd0);
    chk("async reset wbus_oe", 32'(wbus_oe), 32'd0);
    chk("async reset wbus_data", 32'(wbus_data), 32'd0);
    chk("async reset prog_ready", 32'(prog_ready), 32'd0);
    chk("async reset err", 32'(err), 32'd0);
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    rd(8'h00, 4'b0000);
    rd(8'h10, 4'b0000);
    rd(8'h1F, 4'b0000);
    rd(8'h20, 4'b0011);
    rd(8'hFE, 4'b1110);

    repeat (3) cyc();
    chk("outstanding reads", 32'(exp_q.size()), 32'd0);
    chk("err pulse count", 32'(err_seen), 32'(err_expected));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
